// File: rtl/data_mem_reader_pkg.sv
// Shared definitions for the data memory stream reader.
//   ADDR_W    : memory word-address width (4096-word memory)
//   DATA_W    : memory / stream word width
//   MEM_WORDS : number of words in the data memory
//   state_e   : reader FSM states
package data_mem_reader_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_rd_fifo.sv
// Synchronous show-ahead FIFO holding returned memory words plus their
// sop/eop tags until the stream sink accepts them.
//   clk, reset_n : clock, synchronous active-low reset (clears storage too)
//   flush        : empties the FIFO (takes priority over push/pop)
//   push, din    : write one entry
//   pop          : consume the head entry (ignored when empty)
//   dout, valid  : head entry and "not empty"
//   count        : number of stored entries, 0..DEPTH
module data_mem_rd_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    import data_mem_reader_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign valid     = (r_count != '0);
    assign w_do_pop  = pop && valid;
    // A push into a full FIFO is only allowed when the head leaves the same cycle.
    assign w_do_push = push && ((r_count != (PW+1)'(DEPTH)) || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_stream_reader.sv
// Sequential read-out engine for the 4096x32 data memory. Issues word reads
// on the Avalon-MM port (1-cycle read latency) and streams the words out on
// an Avalon-ST source with sop/eop framing and full backpressure.
//   clk, reset_n           : clock, synchronous active-low reset
//   start, abort           : begin a transfer (IDLE only) / cancel it
//   base_addr, length      : first word address, word count (clamped to 4096)
//   busy, done             : transfer in progress / completion pulse
//   mem_*                  : Avalon-MM read master towards the memory
//   st_*                   : Avalon-ST source
//   dbg_state              : current FSM state
// Stream handshake: a word transfers on every rising edge where st_valid and
// st_ready are both high; while st_valid is high and st_ready is low the
// word and its sop/eop tags are held unchanged.
module data_mem_stream_reader #(
    parameter int ADDR_W     = data_mem_reader_pkg::ADDR_W,
    parameter int DATA_W     = data_mem_reader_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic [1:0]        dbg_state
);
    import data_mem_reader_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_first;
    logic              r_inflight;
    logic              r_inflight_sop;
    logic              r_inflight_eop;
    logic              r_done;

    logic [CW-1:0]     w_count;
    logic [CW:0]       w_used;
    logic              w_issue;
    logic              w_pop;
    logic              w_fifo_valid;
    logic [DATA_W+1:0] w_fifo_dout;

    // Credit check: a read is only issued if its return is guaranteed a slot,
    // counting the word still in flight from the previous cycle.
    assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = (r_state == ST_RUN) && !abort && (w_used < (CW+1)'(FIFO_DEPTH));
    assign w_pop   = w_fifo_valid && st_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_first        <= 1'b0;
            r_inflight     <= 1'b0;
            r_inflight_sop <= 1'b0;
            r_inflight_eop <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr         <= r_addr + ADDR_W'(1);
                r_remaining    <= r_remaining - (ADDR_W+1)'(1);
                r_first        <= 1'b0;
                r_inflight_sop <= r_first;
                r_inflight_eop <= (r_remaining == (ADDR_W+1)'(1));
            end
            if (abort) begin
                // Also blocks start when already idle.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (length == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_addr      <= base_addr;
                                r_remaining <= (length > LEN_MAX) ? LEN_MAX : length;
                                r_first     <= 1'b1;
                                r_state     <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_issue && (r_remaining == (ADDR_W+1)'(1))) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // Bit 0 of the FIFO head is the eop tag.
                        if (w_pop && w_fifo_dout[0]) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // The returned word is pushed the cycle after its issue; abort flushes
    // the FIFO and the flush wins over that push, discarding the return.
    data_mem_rd_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (abort),
        .push    (r_inflight),
        .din     ({mem_readdata, r_inflight_sop, r_inflight_eop}),
        .pop     (w_pop),
        .dout    (w_fifo_dout),
        .valid   (w_fifo_valid),
        .count   (w_count)
    );

    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign mem_address    = r_addr;
    assign mem_chipselect = w_issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign st_valid       = w_fifo_valid;
    assign st_data        = w_fifo_dout[DATA_W+1:2];
    assign st_sop         = w_fifo_dout[1];
    assign st_eop         = w_fifo_dout[0];
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_data_mem_stream_reader.sv
module tb_data_mem_stream_reader;

    localparam int MEM_WORDS = data_mem_reader_pkg::MEM_WORDS;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic        busy;
    logic        done;
    logic [11:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop;
    logic        st_eop;
    logic [1:0]  dbg_state;

    logic [31:0] mem [MEM_WORDS];
    logic [11:0] mem_addr_q;
    logic [33:0] exp_q[$];
    int          n_total;
    int          n_pass;

    typedef struct {
        logic [11:0] base;
        logic [12:0] len;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    data_mem_stream_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .dbg_state      (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: address registered on the chipselect edge, data read combinationally.
    always @(posedge clk) begin
        if (mem_chipselect) mem_addr_q <= mem_address;
    end
    assign mem_readdata = mem[mem_addr_q];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Scoreboard: every accepted beat is compared against the queue head.
    always @(negedge clk) begin
        if (st_valid === 1'b1 && st_ready === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got data %h sop %0b eop %0b, expected no beat",
                         st_data, st_sop, st_eop);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({st_data, st_sop, st_eop} === e) n_pass++;
                else $display("FAIL beat: got data %h sop %0b eop %0b, expected data %h sop %0b eop %0b",
                              st_data, st_sop, st_eop, e[33:2], e[1], e[0]);
            end
        end
    end

    task automatic push_expected(input logic [11:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            logic [11:0] a;
            a = base + 12'(k);
            exp_q.push_back({mem[a], (k == 0), (k == n - 1)});
        end
    endtask

    // Called #1 after a clock edge; returns #1 after a later edge.
    task automatic run_xfer(input logic [11:0] base, input logic [12:0] len, input int exp_done);
        int n;
        int done_cyc;
        int first_v;
        bit saw_busy;
        bit saw_cs;
        n = (len > 13'd4096) ? 4096 : int'(len);
        push_expected(base, n);
        start = 1'b1; base_addr = base; length = len;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1; first_v = -1; saw_busy = 1'b0; saw_cs = 1'b0;
        for (int cyc = 1; cyc <= n + 20; cyc++) begin
            if (cyc == 1 && n > 0) begin
                check("busy_cycle1", busy, 1);
                check("cs_cycle1", mem_chipselect, 1);
                check("addr_cycle1", mem_address, base);
            end
            if (busy) saw_busy = 1'b1;
            if (mem_chipselect) saw_cs = 1'b1;
            if (st_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check("done_cycle", done_cyc, exp_done);
        if (n == 0) begin
            check("len0_busy_never", saw_busy, 0);
            check("len0_no_cs", saw_cs, 0);
        end else begin
            check("first_valid_cycle", first_v, 3);
            check("busy_low_at_done", busy, 0);
        end
        check("all_beats_seen", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int cs_cnt;
        bit bad;
        bit got_done;
        logic [11:0] rb;
        logic [12:0] rl;

        vecs[0] = '{base: 12'h010, len: 13'd4,    exp_done: 7};
        vecs[1] = '{base: 12'hFFE, len: 13'd4,    exp_done: 7};
        vecs[2] = '{base: 12'h123, len: 13'd1,    exp_done: 4};
        vecs[3] = '{base: 12'h000, len: 13'd0,    exp_done: 1};
        vecs[4] = '{base: 12'h800, len: 13'd5000, exp_done: 4099};

        n_total = 0; n_pass = 0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i);
        mem_addr_q = '0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; st_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_addr", mem_address, 0);
        check("rst_valid", st_valid, 0);
        check("rst_sop", st_sop, 0);
        check("rst_eop", st_eop, 0);
        check("rst_data", st_data, 0);
        check("rst_state", dbg_state, 0);
        check("mem_write_tie", mem_write, 0);
        check("byteenable_tie", mem_byteenable, 4'hF);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven transfers with ready held high
        for (int v = 0; v < 5; v++) run_xfer(vecs[v].base, vecs[v].len, vecs[v].exp_done);

        // Random-sized transfer
        rb = 12'($urandom_range(0, 4095));
        rl = 13'($urandom_range(2, 20));
        run_xfer(rb, rl, int'(rl) + 3);

        // Backpressure: ready low in cycles 3..12
        push_expected(12'h100, 6);
        start = 1'b1; base_addr = 12'h100; length = 13'd6;
        @(posedge clk); #1;
        start = 1'b0;
        cs_cnt = 0; bad = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 3) st_ready = 1'b0;
            if (mem_chipselect) cs_cnt++;
            if (cyc >= 3) begin
                if (!(st_valid === 1'b1 && st_data === mem[12'h100] && st_sop === 1'b1)) bad = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("bp_reads_bounded", (cs_cnt <= 4), 1);
        check("bp_head_held", bad, 0);
        st_ready = 1'b1;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            if (done) got_done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("bp_done", got_done, 1);
        check("bp_all_beats", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;

        // Abort in cycle 4 of a length-8 transfer
        push_expected(12'h080, 8);
        start = 1'b1; base_addr = 12'h080; length = 13'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", st_valid, 0);
        check("abort_done", done, 0);
        check("abort_beats_before", exp_q.size(), 6);
        exp_q.delete();
        bad = 1'b0;
        repeat (5) begin
            if (done || st_valid || mem_chipselect) bad = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_quiet", bad, 0);
        run_xfer(12'h300, 13'd2, 5);

        // Abort beats start while idle
        start = 1'b1; abort = 1'b1; base_addr = 12'h050; length = 13'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_prio_busy", busy, 0);
        check("abort_prio_done", done, 0);
        check("abort_prio_cs", mem_chipselect, 0);
        @(posedge clk); #1;

        // Reset pulse mid-transfer
        push_expected(12'h040, 8);
        start = 1'b1; base_addr = 12'h040; length = 13'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cs", mem_chipselect, 0);
        check("mid_rst_addr", mem_address, 0);
        check("mid_rst_valid", st_valid, 0);
        check("mid_rst_sop", st_sop, 0);
        check("mid_rst_eop", st_eop, 0);
        check("mid_rst_data", st_data, 0);
        reset_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        run_xfer(12'h7FD, 13'd5, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
